// File: rtl/next_hop_select.sv
// Next-hop selector: scans the neighbour table in node memory, picks the eligible
// neighbour with the highest Q-value and writes its ID and Q back to memory.
module next_hop_select #(
  parameter int          MAX_NEIGHBORS = 32,
  parameter logic [15:0] MIN_ENERGY    = 16'd0,
  parameter logic [10:0] NEXTHOP_ADDR  = 11'h2A0,
  parameter logic [10:0] NEXTHOPQ_ADDR = 11'h2A2
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic [15:0] data_in,
  input  logic [15:0] myClusterID,
  output logic [10:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic [15:0] nextHop,
  output logic [15:0] nextHopQ,
  output logic        found,
  output logic        done
);

  localparam int            CW       = $clog2(MAX_NEIGHBORS + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_NEIGHBORS);
  localparam logic [10:0]   CNT_ADDR = 11'h274;
  localparam logic [10:0]   ID_BASE  = 11'h072;
  localparam logic [10:0]   CID_BASE = 11'h0B2;
  localparam logic [10:0]   EN_BASE  = 11'h0F2;
  localparam logic [10:0]   Q_BASE   = 11'h132;

  typedef enum logic [3:0] {
    IDLE, RD_CNT, LATCH_CNT, E_ID, E_CID, E_EN, E_Q, E_EVAL, WR_HOP, WR_Q, FIN
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, n, n_inc, cnt_in;
  logic          rd_wait;
  logic [15:0]   cur_id, cur_cid, cur_energy;
  logic [15:0]   best_id, best_q;
  logic          best_valid;
  logic [10:0]   entry_off, addr_d;
  logic [15:0]   dout_d;
  logic          wr_d;
  logic [16:0]   energy_diff;
  logic          eligible, take;

  assign cnt_in      = (data_in > 16'(MAX_NEIGHBORS)) ? MAX_CNT : data_in[CW-1:0];
  assign n_inc       = n + 1'b1;
  assign entry_off   = 11'({n, 1'b0});
  // Energy check via borrow bit, so MIN_ENERGY = 0 never becomes a constant compare.
  assign energy_diff = {1'b0, cur_energy} - {1'b0, MIN_ENERGY};
  assign eligible    = ((cur_cid == myClusterID) || (cur_id == myClusterID)) && !energy_diff[16];
  assign take        = eligible && (!best_valid || (data_in > best_q));

  always_ff @(posedge clock) begin
    if (!nrst) state <= IDLE;
    else       state <= state_d;
  end

  // The count word gets a two-cycle read slot before it is latched.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (en) state_d = RD_CNT;
      RD_CNT:    state_d = rd_wait ? LATCH_CNT : RD_CNT;
      LATCH_CNT: state_d = (cnt_in == '0) ? WR_HOP : E_ID;
      E_ID:      state_d = E_CID;
      E_CID:     state_d = E_EN;
      E_EN:      state_d = E_Q;
      E_Q:       state_d = E_EVAL;
      E_EVAL:    state_d = (n_inc == cnt) ? WR_HOP : E_ID;
      WR_HOP:    state_d = WR_Q;
      WR_Q:      state_d = FIN;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = address;
    dout_d = data_out;
    wr_d   = 1'b0;
    case (state)
      RD_CNT: addr_d = CNT_ADDR;
      E_ID:   addr_d = ID_BASE + entry_off;
      E_CID:  addr_d = CID_BASE + entry_off;
      E_EN:   addr_d = EN_BASE + entry_off;
      E_Q:    addr_d = Q_BASE + entry_off;
      WR_HOP: begin
        addr_d = NEXTHOP_ADDR;
        dout_d = best_id;
        wr_d   = 1'b1;
      end
      WR_Q: begin
        addr_d = NEXTHOPQ_ADDR;
        dout_d = best_q;
        wr_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      address    <= '0;
      data_out   <= '0;
      wr_en      <= 1'b0;
      nextHop    <= 16'hFFFF;
      nextHopQ   <= '0;
      found      <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      n          <= '0;
      rd_wait    <= 1'b0;
      cur_id     <= '0;
      cur_cid    <= '0;
      cur_energy <= '0;
      best_id    <= 16'hFFFF;
      best_q     <= '0;
      best_valid <= 1'b0;
    end else begin
      address  <= addr_d;
      data_out <= dout_d;
      wr_en    <= wr_d;
      case (state)
        IDLE: if (en) begin
          done       <= 1'b0;
          found      <= 1'b0;
          best_id    <= 16'hFFFF;
          best_q     <= '0;
          best_valid <= 1'b0;
          n          <= '0;
          rd_wait    <= 1'b0;
        end
        RD_CNT:    rd_wait <= 1'b1;
        LATCH_CNT: cnt <= cnt_in;
        E_CID:     cur_id <= data_in;
        E_EN:      cur_cid <= data_in;
        E_Q:       cur_energy <= data_in;
        E_EVAL: begin
          if (take) begin
            best_id    <= cur_id;
            best_q     <= data_in;
            best_valid <= 1'b1;
          end
          n <= n_inc;
        end
        FIN: begin
          nextHop  <= best_id;
          nextHopQ <= best_q;
          found    <= best_valid;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_next_hop_select.sv
// Directed bench for next_hop_select: table of neighbour sets with expected picks,
// plus hand-written sequences for clamping, mid-scan reset and ignored en pulses.
module tb_next_hop_select;

  logic        clock = 1'b0;
  logic        nrst, en;
  logic [15:0] data_in, myClusterID;
  logic [10:0] address;
  logic [15:0] data_out, nextHop, nextHopQ;
  logic        wr_en, found, done;

  logic [15:0] mem [0:2047];
  int          total_checks  = 0;
  int          passed_checks = 0;

  typedef struct packed {
    logic [5:0]        cnt;
    logic [15:0]       my_cid;
    logic [3:0][15:0]  id, cid, energy, q;
    logic [15:0]       exp_hop, exp_q;
    logic              exp_found;
  } vec_t;

  vec_t vecs [8];

  always #5 clock = ~clock;

  // Combinational read port: data for the registered address is valid next cycle.
  assign data_in = mem[address];

  next_hop_select #(.MIN_ENERGY(16'd100)) dut (
    .clock(clock), .nrst(nrst), .en(en), .data_in(data_in),
    .myClusterID(myClusterID), .address(address), .data_out(data_out),
    .wr_en(wr_en), .nextHop(nextHop), .nextHopQ(nextHopQ),
    .found(found), .done(done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic load_table(input vec_t v);
    mem[11'h274] = {10'd0, v.cnt};
    for (int i = 0; i < 4; i++) begin
      mem[11'h072 + 2*i] = v.id[i];
      mem[11'h0B2 + 2*i] = v.cid[i];
      mem[11'h0F2 + 2*i] = v.energy[i];
      mem[11'h132 + 2*i] = v.q[i];
    end
  endtask

  // Starts a run, counts edges until done, and logs writes and the highest table read.
  task automatic run_scan(input int pulse_at, output int edges, output int wr_cnt,
                          output logic [15:0] hop_wr, output logic [15:0] q_wr,
                          output logic [10:0] max_rd);
    hop_wr = 16'h1234;
    q_wr   = 16'h1234;
    wr_cnt = 0;
    max_rd = '0;
    edges  = 0;
    @(negedge clock) en = 1'b1;
    @(posedge clock);
    #1 en = 1'b0;
    while (edges < 400) begin
      @(posedge clock);
      edges++;
      #1;
      en = (pulse_at != 0) && (edges == pulse_at);
      if (done) break;
      if (wr_en) begin
        wr_cnt++;
        if (address == 11'h2A0)      hop_wr = data_out;
        else if (address == 11'h2A2) q_wr = data_out;
      end else if (address != 11'h274 && address > max_rd) begin
        max_rd = address;
      end
    end
    en = 1'b0;
    if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic applyStimulus(input int k, input int pulse_at);
    int          edges, wr_cnt;
    logic [15:0] hop_wr, q_wr;
    logic [10:0] max_rd;
    string       tag;
    load_table(vecs[k]);
    myClusterID = vecs[k].my_cid;
    run_scan(pulse_at, edges, wr_cnt, hop_wr, q_wr, max_rd);
    tag = $sformatf("vec%0d", k);
    checkOutput({tag, "_latency"}, edges, 6 + 5 * int'(vecs[k].cnt));
    checkOutput({tag, "_nextHop"}, nextHop, vecs[k].exp_hop);
    checkOutput({tag, "_nextHopQ"}, nextHopQ, vecs[k].exp_q);
    checkOutput({tag, "_found"}, found, vecs[k].exp_found);
    checkOutput({tag, "_wr_cycles"}, wr_cnt, 2);
    checkOutput({tag, "_wr_hop"}, hop_wr, vecs[k].exp_hop);
    checkOutput({tag, "_wr_q"}, q_wr, vecs[k].exp_q);
  endtask

  initial begin
    int          edges, wr_cnt, idle_bad;
    logic [15:0] hop_wr, q_wr;
    logic [10:0] max_rd;

    vecs[0] = '{cnt: 6'd3, my_cid: 16'd5,
                id: {16'd0, 16'd12, 16'd11, 16'd10}, cid: {16'd0, 16'd7, 16'd5, 16'd5},
                energy: {16'd0, 16'd200, 16'd200, 16'd200}, q: {16'd0, 16'd900, 16'd300, 16'd100},
                exp_hop: 16'd11, exp_q: 16'd300, exp_found: 1'b1};
    vecs[1] = '{cnt: 6'd2, my_cid: 16'd5,
                id: {16'd0, 16'd0, 16'd21, 16'd20}, cid: {16'd0, 16'd0, 16'd5, 16'd5},
                energy: {16'd0, 16'd0, 16'd200, 16'd200}, q: {16'd0, 16'd0, 16'd50, 16'd50},
                exp_hop: 16'd20, exp_q: 16'd50, exp_found: 1'b1};
    vecs[2] = '{cnt: 6'd3, my_cid: 16'd9,
                id: {16'd0, 16'd9, 16'd21, 16'd20}, cid: {16'd0, 16'd4, 16'd9, 16'd9},
                energy: {16'd0, 16'd200, 16'd200, 16'd200}, q: {16'd0, 16'd60, 16'd50, 16'd50},
                exp_hop: 16'd9, exp_q: 16'd60, exp_found: 1'b1};
    vecs[3] = '{cnt: 6'd0, my_cid: 16'd5,
                id: {16'd0, 16'd0, 16'd0, 16'd10}, cid: {16'd0, 16'd0, 16'd0, 16'd5},
                energy: {16'd0, 16'd0, 16'd0, 16'd200}, q: {16'd0, 16'd0, 16'd0, 16'd77},
                exp_hop: 16'hFFFF, exp_q: 16'd0, exp_found: 1'b0};
    vecs[4] = '{cnt: 6'd3, my_cid: 16'd5,
                id: {16'd0, 16'd12, 16'd11, 16'd10}, cid: {16'd0, 16'd5, 16'd5, 16'd5},
                energy: {16'd0, 16'd50, 16'd0, 16'd99}, q: {16'd0, 16'd3, 16'd2, 16'd1},
                exp_hop: 16'hFFFF, exp_q: 16'd0, exp_found: 1'b0};
    vecs[5] = '{cnt: 6'd2, my_cid: 16'd5,
                id: {16'd0, 16'd0, 16'd31, 16'd30}, cid: {16'd0, 16'd0, 16'd5, 16'd5},
                energy: {16'd0, 16'd0, 16'd100, 16'd99}, q: {16'd0, 16'd0, 16'd40, 16'd500},
                exp_hop: 16'd31, exp_q: 16'd40, exp_found: 1'b1};
    vecs[6] = '{cnt: 6'd3, my_cid: 16'd5,
                id: {16'd0, 16'd42, 16'd41, 16'd40}, cid: {16'd0, 16'd6, 16'd5, 16'd5},
                energy: {16'd0, 16'd200, 16'd200, 16'd200}, q: {16'd0, 16'hFFFF, 16'h8000, 16'h7FFF},
                exp_hop: 16'd41, exp_q: 16'h8000, exp_found: 1'b1};
    vecs[7] = '{cnt: 6'd1, my_cid: 16'd5,
                id: {16'd0, 16'd0, 16'd0, 16'd50}, cid: {16'd0, 16'd0, 16'd0, 16'd5},
                energy: {16'd0, 16'd0, 16'd0, 16'd100}, q: {16'd0, 16'd0, 16'd0, 16'd0},
                exp_hop: 16'd50, exp_q: 16'd0, exp_found: 1'b1};

    for (int i = 0; i < 2048; i++) mem[i] = 16'd0;
    nrst = 1'b0;
    en = 1'b0;
    myClusterID = 16'd0;
    repeat (2) @(posedge clock);
    @(negedge clock) nrst = 1'b1;

    #1;
    checkOutput("rst_nextHop", nextHop, 16'hFFFF);
    checkOutput("rst_nextHopQ", nextHopQ, 16'd0);
    checkOutput("rst_found", found, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_wr_en", wr_en, 1'b0);
    checkOutput("rst_address", address, 11'd0);
    idle_bad = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (nextHop !== 16'hFFFF || found !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 ||
          address !== 11'd0 || data_out !== 16'd0) idle_bad++;
    end
    checkOutput("idle_stable", idle_bad, 0);

    for (int k = 0; k < 8; k++) applyStimulus(k, 0);

    // en pulses mid-scan must not restart or disturb the run.
    applyStimulus(0, 5);
    applyStimulus(6, 12);

    // Count of 40 clamps to 32 entries; entries past 31 carry a larger Q as bait.
    mem[11'h274] = 16'd40;
    for (int i = 0; i < 40; i++) begin
      mem[11'h072 + 2*i] = 16'(100 + i);
      mem[11'h0B2 + 2*i] = 16'd5;
      mem[11'h0F2 + 2*i] = 16'd200;
      mem[11'h132 + 2*i] = (i < 32) ? 16'(i * 10) : 16'd60000;
    end
    myClusterID = 16'd5;
    run_scan(0, edges, wr_cnt, hop_wr, q_wr, max_rd);
    checkOutput("clamp_latency", edges, 166);
    checkOutput("clamp_max_addr", max_rd, 11'h170);
    checkOutput("clamp_nextHop", nextHop, 16'd131);
    checkOutput("clamp_nextHopQ", nextHopQ, 16'd310);
    checkOutput("clamp_wr_hop", hop_wr, 16'd131);

    // Reset during entry 2 of a 4-entry scan.
    load_table('{cnt: 6'd4, my_cid: 16'd5,
                 id: {16'd63, 16'd62, 16'd61, 16'd60}, cid: {16'd5, 16'd5, 16'd5, 16'd5},
                 energy: {16'd200, 16'd200, 16'd200, 16'd200}, q: {16'd4, 16'd3, 16'd2, 16'd1},
                 exp_hop: 16'd63, exp_q: 16'd4, exp_found: 1'b1});
    @(negedge clock) en = 1'b1;
    @(posedge clock);
    #1 en = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock) nrst = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midrst_nextHop", nextHop, 16'hFFFF);
    checkOutput("midrst_nextHopQ", nextHopQ, 16'd0);
    checkOutput("midrst_found", found, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_wr_en", wr_en, 1'b0);
    checkOutput("midrst_address", address, 11'd0);
    @(negedge clock) nrst = 1'b1;
    wr_cnt = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (wr_en || done) wr_cnt++;
    end
    checkOutput("midrst_quiet", wr_cnt, 0);
    run_scan(0, edges, wr_cnt, hop_wr, q_wr, max_rd);
    checkOutput("postrst_latency", edges, 26);
    checkOutput("postrst_nextHop", nextHop, 16'd63);
    checkOutput("postrst_wr_q", q_wr, 16'd4);
    checkOutput("postrst_wr_cycles", wr_cnt, 2);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
